// File: rtl/accumulator_stream_framer.sv
// accumulator_stream_framer
// Slices an upstream element stream into vectors for floating_point_accumulator
// and buffers the returned per-vector sums in a small result FIFO. A vector is
// only started once a FIFO slot is reserved for its sum, because the
// accumulator cannot be backpressured.
// Optional build macro: ACC_FRAMER_ERR_EN enables the sticky errOut checks.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a start with non-zero length and count
// S_STREAM | accepting elements and forwarding them to the accumulator
// S_DRAIN  | all vectors issued; waiting for every result to be popped
module accumulator_stream_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [LEN_WIDTH-1:0]  lengthIn,
  input  logic [CNT_WIDTH-1:0]  countIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  output logic                  readyOut,
  output logic [DATA_WIDTH-1:0] accDataOut,
  output logic                  accValidOut,
  output logic                  accLastOut,
  input  logic [DATA_WIDTH-1:0] accResultIn,
  input  logic                  accResultValidIn,
  output logic [DATA_WIDTH-1:0] resultDataOut,
  output logic                  resultValidOut,
  input  logic                  resultReadyIn,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic                  errOut
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CRD_W = PTR_W + 1;
  localparam logic [CRD_W-1:0]     CRD_FULL = CRD_W'(FIFO_DEPTH);
  localparam logic [CRD_W-1:0]     CRD_ONE  = CRD_W'(1);
  localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [LEN_WIDTH-1:0]  r_length;
  logic [LEN_WIDTH-1:0]  r_elem_cnt;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [CNT_WIDTH-1:0]  r_vec_cnt;
  logic [CNT_WIDTH-1:0]  r_issued_vec;
  logic [CRD_W-1:0]      r_reserved;

  logic [DATA_WIDTH-1:0] r_acc_data;
  logic                  r_acc_valid;
  logic                  r_acc_last;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CRD_W-1:0]      r_fifo_cnt;

  logic w_start_ok;
  logic w_ready;
  logic w_xfer;
  logic w_elem_last;
  logic w_vec_first;
  logic w_job_last;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_pop;
  logic w_push;
  logic w_drain_done;

  assign w_start_ok   = startIn && (lengthIn != '0) && (countIn != '0);
  // Stalls are only allowed between vectors: mid-vector the slot is already held.
  assign w_ready      = (r_state == S_STREAM) &&
                        ((r_elem_cnt != '0) || (r_reserved < CRD_FULL));
  assign w_xfer       = validIn && w_ready;
  assign w_elem_last  = (r_elem_cnt == (r_length - LEN_ONE));
  assign w_vec_first  = w_xfer && (r_elem_cnt == '0);
  assign w_job_last   = w_xfer && w_elem_last && (r_vec_cnt == (r_count - CNT_ONE));
  assign w_fifo_full  = (r_fifo_cnt == CRD_FULL);
  assign w_fifo_empty = (r_fifo_cnt == '0);
  assign w_pop        = !w_fifo_empty && resultReadyIn;
  assign w_push       = accResultValidIn && (!w_fifo_full || w_pop);
  assign w_drain_done = (r_state == S_DRAIN) && (r_reserved == '0) &&
                        (r_issued_vec == r_count);

  assign readyOut       = w_ready;
  assign accDataOut     = r_acc_data;
  assign accValidOut    = r_acc_valid;
  assign accLastOut     = r_acc_last;
  assign resultValidOut = !w_fifo_empty;
  assign resultDataOut  = w_fifo_empty ? '0 : r_mem[r_rd_ptr];
  assign busyOut        = (r_state != S_IDLE);
  assign doneOut        = w_drain_done;

  // State register.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok)   w_next_state = S_STREAM;
      S_STREAM: if (w_job_last)   w_next_state = S_DRAIN;
      S_DRAIN:  if (w_drain_done) w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  // Job configuration and element/vector position counters.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_length     <= '0;
      r_count      <= '0;
      r_elem_cnt   <= '0;
      r_vec_cnt    <= '0;
      r_issued_vec <= '0;
    end else if ((r_state == S_IDLE) && w_start_ok) begin
      r_length     <= lengthIn;
      r_count      <= countIn;
      r_elem_cnt   <= '0;
      r_vec_cnt    <= '0;
      r_issued_vec <= '0;
    end else if (w_xfer) begin
      if (w_elem_last) begin
        r_elem_cnt <= '0;
        r_vec_cnt  <= r_vec_cnt + CNT_ONE;
      end else begin
        r_elem_cnt <= r_elem_cnt + LEN_ONE;
      end
      if (r_elem_cnt == '0) r_issued_vec <= r_issued_vec + CNT_ONE;
    end
  end

  // FIFO credit: taken when a vector starts, returned when its sum is popped.
  // Saturates at zero so stray results popped outside a job cannot underflow it.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_reserved <= '0;
    end else begin
      case ({w_vec_first, w_pop})
        2'b10:   r_reserved <= r_reserved + CRD_ONE;
        2'b01:   if (r_reserved != '0) r_reserved <= r_reserved - CRD_ONE;
        default: r_reserved <= r_reserved;
      endcase
    end
  end

  // Registered element path to the accumulator.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_acc_data  <= '0;
      r_acc_valid <= 1'b0;
      r_acc_last  <= 1'b0;
    end else begin
      r_acc_valid <= w_xfer;
      r_acc_last  <= w_xfer && w_elem_last;
      if (w_xfer) r_acc_data <= dataIn;
    end
  end

  // Result storage; output is gated to zero when empty, so no reset needed here.
  always_ff @(posedge clkIn) begin
    if (w_push) r_mem[r_wr_ptr] <= accResultIn;
  end

  // Result FIFO pointers and occupancy.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CRD_ONE;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CRD_ONE;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

`ifdef ACC_FRAMER_ERR_EN
  logic [CNT_WIDTH-1:0] r_res_cnt;
  logic                 r_err;

  // Sticky error on overflow or on a result nobody asked for.
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      r_res_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_start_ok) r_res_cnt <= '0;
      else if (accResultValidIn)             r_res_cnt <= r_res_cnt + CNT_ONE;
      if (accResultValidIn &&
          ((w_fifo_full && !w_pop) || (r_issued_vec == r_res_cnt)))
        r_err <= 1'b1;
    end
  end

  assign errOut = r_err;
`else
  assign errOut = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_stream_framer.sv
// Bench for accumulator_stream_framer with a 2-entry result FIFO so that
// credit stalls are reachable. The accumulator is modelled as an integer
// adder that returns each vector sum one cycle after its last element.
module tb_accumulator_stream_framer;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int CW = 16;
  localparam int FD = 2;

  logic          clkIn;
  logic          rstIn;
  logic          startIn;
  logic [LW-1:0] lengthIn;
  logic [CW-1:0] countIn;
  logic [DW-1:0] dataIn;
  logic          validIn;
  logic          readyOut;
  logic [DW-1:0] accDataOut;
  logic          accValidOut;
  logic          accLastOut;
  logic [DW-1:0] accResultIn;
  logic          accResultValidIn;
  logic [DW-1:0] resultDataOut;
  logic          resultValidOut;
  logic          resultReadyIn;
  logic          busyOut;
  logic          doneOut;
  logic          errOut;

  accumulator_stream_framer #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)
  ) dut (
    .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn),
    .lengthIn(lengthIn), .countIn(countIn),
    .dataIn(dataIn), .validIn(validIn), .readyOut(readyOut),
    .accDataOut(accDataOut), .accValidOut(accValidOut), .accLastOut(accLastOut),
    .accResultIn(accResultIn), .accResultValidIn(accResultValidIn),
    .resultDataOut(resultDataOut), .resultValidOut(resultValidOut),
    .resultReadyIn(resultReadyIn),
    .busyOut(busyOut), .doneOut(doneOut), .errOut(errOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  typedef struct {
    int len;
    int cnt;
    int base;
    bit toggle;
    int hold;
    int exp_stall;
    int exp_last;
  } job_t;

  job_t jobs[5];
  int   n_checks;
  int   n_errors;
  int   acc_sum;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int vec_sum(input int len, input int base, input int v);
    return len * (base + v * len) + (len * (len - 1)) / 2;
  endfunction

  task automatic tick();
    @(negedge clkIn);
    accResultValidIn = 1'b0;
    if (accValidOut) begin
      acc_sum += int'(accDataOut);
      if (accLastOut) begin
        accResultIn      = acc_sum;
        accResultValidIn = 1'b1;
        acc_sum          = 0;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, ".readyOut"},       int'(readyOut),       0);
    chk({tag, ".accValidOut"},    int'(accValidOut),    0);
    chk({tag, ".accLastOut"},     int'(accLastOut),     0);
    chk({tag, ".accDataOut"},     int'(accDataOut),     0);
    chk({tag, ".resultValidOut"}, int'(resultValidOut), 0);
    chk({tag, ".resultDataOut"},  int'(resultDataOut),  0);
    chk({tag, ".busyOut"},        int'(busyOut),        0);
    chk({tag, ".doneOut"},        int'(doneOut),        0);
    chk({tag, ".errOut"},         int'(errOut),         0);
  endtask

  task automatic run_job(input int id, input job_t j);
    int e, out_idx, res_idx, cyc, lasts, last_res;
    bit done_seen, valid, xfer, pop;
    string t;
    t = $sformatf("job%0d", id);
    e = 0; out_idx = 0; res_idx = 0; cyc = 0; lasts = 0; last_res = -1;
    done_seen = 1'b0;
    lengthIn      = LW'(j.len);
    countIn       = CW'(j.cnt);
    startIn       = 1'b1;
    validIn       = 1'b0;
    resultReadyIn = (j.hold == 0);
    tick();
    startIn = 1'b0;
    chk({t, ".busy_after_start"}, int'(busyOut), 1);
    while (!done_seen && cyc < 300) begin
      valid         = (e < j.len * j.cnt) && (!j.toggle || (cyc % 2 == 0));
      validIn       = valid;
      dataIn        = j.base + e;
      resultReadyIn = (cyc >= j.hold);
      xfer          = valid && readyOut;
      pop           = resultValidOut && resultReadyIn;
      if (pop) begin
        chk($sformatf("%s.result%0d", t, res_idx), int'(resultDataOut),
            vec_sum(j.len, j.base, res_idx));
        last_res = int'(resultDataOut);
        res_idx++;
      end
      tick();
      if (xfer) e++;
      cyc++;
      if (accValidOut) begin
        chk($sformatf("%s.accData%0d", t, out_idx), int'(accDataOut), j.base + out_idx);
        chk($sformatf("%s.accLast%0d", t, out_idx), int'(accLastOut),
            ((out_idx + 1) % j.len == 0) ? 1 : 0);
        if (accLastOut) lasts++;
        out_idx++;
      end
      if (j.hold > 0 && cyc == j.hold) begin
        chk({t, ".stall_xfers"}, e, j.exp_stall);
        chk({t, ".stall_ready"}, int'(readyOut), 0);
      end
      if (doneOut) begin
        done_seen = 1'b1;
        chk({t, ".results_before_done"}, res_idx, j.cnt);
      end
    end
    validIn = 1'b0;
    chk({t, ".done_seen"},  int'(done_seen), 1);
    chk({t, ".last_count"}, lasts, j.cnt);
    chk({t, ".last_result"}, last_res, j.exp_last);
    tick();
    chk({t, ".busy_after_done"}, int'(busyOut), 0);
    chk({t, ".done_one_cycle"},  int'(doneOut), 0);
    chk({t, ".fifo_empty"},      int'(resultValidOut), 0);
    chk({t, ".err"},             int'(errOut), 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    acc_sum  = 0;
    rstIn = 1'b1; startIn = 1'b0; lengthIn = '0; countIn = '0;
    dataIn = '0; validIn = 1'b0; accResultIn = '0; accResultValidIn = 1'b0;
    resultReadyIn = 1'b0;

    //            len cnt base tog hold stall last
    jobs[0] = '{4,  3,  1,   0,  0,   0,    42};
    jobs[1] = '{3,  2,  1,   1,  0,   0,    15};
    jobs[2] = '{1,  3,  7,   0,  0,   0,     9};
    jobs[3] = '{2,  1,  100, 0,  0,   0,   201};
    jobs[4] = '{1,  5,  1,   0,  10,  2,     5};

    tick(); tick();
    check_zero_outputs("reset");
    rstIn = 1'b0;
    tick();

    // Zero length or zero count must not leave IDLE.
    lengthIn = '0; countIn = 16'd3; startIn = 1'b1;
    tick(); startIn = 1'b0; tick();
    chk("zero_len.busy",  int'(busyOut),  0);
    chk("zero_len.ready", int'(readyOut), 0);
    lengthIn = 16'd4; countIn = '0; startIn = 1'b1;
    tick(); startIn = 1'b0; tick();
    chk("zero_cnt.busy",  int'(busyOut),  0);
    chk("zero_cnt.ready", int'(readyOut), 0);

    for (int i = 0; i < 5; i++) run_job(i, jobs[i]);

    // Stray accumulator result while IDLE.
    resultReadyIn    = 1'b0;
    accResultIn      = 32'd123;
    accResultValidIn = 1'b1;
    tick();
`ifdef ACC_FRAMER_ERR_EN
    chk("stray.err_set", int'(errOut), 1);
    tick(); tick(); tick();
    chk("stray.err_held", int'(errOut), 1);
`else
    chk("stray.err_off", int'(errOut), 0);
    chk("stray.pushed_valid", int'(resultValidOut), 1);
    chk("stray.pushed_data",  int'(resultDataOut), 123);
`endif
    rstIn = 1'b1;
    tick();
    chk("stray.err_cleared", int'(errOut), 0);
    chk("stray.fifo_cleared", int'(resultValidOut), 0);
    rstIn = 1'b0;
    tick();

    // Reset mid-vector with a result sitting in the FIFO.
    lengthIn = 16'd4; countIn = 16'd1; startIn = 1'b1; resultReadyIn = 1'b0;
    tick();
    startIn = 1'b0;
    validIn = 1'b1; dataIn = 32'd50;
    accResultIn = 32'd99; accResultValidIn = 1'b1;
    tick();
    dataIn = 32'd51;
    tick();
    validIn = 1'b0;
    chk("midrst.pre_accValid",    int'(accValidOut),    1);
    chk("midrst.pre_resultValid", int'(resultValidOut), 1);
    chk("midrst.pre_busy",        int'(busyOut),        1);
    #2 rstIn = 1'b1;
    #1 check_zero_outputs("midrst");
    tick();
    rstIn   = 1'b0;
    acc_sum = 0;
    tick();
    run_job(5, jobs[3]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
